// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared definitions for the data-memory load/store sequencer:
// funct3 encodings, FSM state encoding and the alignment predicate.
package dmem_lsu_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR_MIS = 3'd4,
        ST_ERR_BUS = 3'd5
    } lsu_state_t;

    // size is funct3[1:0]: 00 byte, 01 halfword, 1x word.
    // Bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size[1])
            mis = |addr_lo;
        else if (size[0])
            mis = addr_lo[0];
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_dmem.sv
// Sub-word unit: word-aligns the address, builds the byte-lane mask,
// lane-shifts store data and extracts/extends load data.
module dmem_lsu_ctrl_dmem
    import dmem_lsu_ctrl_pkg::*;
(
    input  logic [2:0]  opsel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    output logic [31:0] ext_rdata
);

    logic [31:0] lane;

    assign mem_addr = {addr[31:2], 2'b00};
    assign lane     = mem_rdata >> {addr[1:0], 3'b000};

    // Byte-lane mask from access size and low address bits
    always_comb begin
        mem_mask = 4'b0000;
        case (opsel[1:0])
            2'b00:   mem_mask = 4'b0001 << addr[1:0];
            2'b01:   mem_mask = 4'b0011 << {addr[1], 1'b0};
            default: mem_mask = 4'b1111;
        endcase
    end

    // Move store data onto the lanes selected by the address
    always_comb begin
        mem_wdata = '0;
        case (opsel)
            F3_SB:   mem_wdata = {24'b0, wdata[7:0]} << {addr[1:0], 3'b000};
            F3_SH:   mem_wdata = {16'b0, wdata[15:0]} << {addr[1], 4'b0000};
            F3_SW:   mem_wdata = wdata;
            default: mem_wdata = wdata;
        endcase
    end

    // Sign- or zero-extend the addressed sub-word of the returned word
    always_comb begin
        ext_rdata = mem_rdata;
        case (opsel)
            F3_LB:   ext_rdata = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   ext_rdata = {{16{lane[15]}}, lane[15:0]};
            F3_LW:   ext_rdata = lane;
            F3_LBU:  ext_rdata = {24'b0, lane[7:0]};
            F3_LHU:  ext_rdata = {16'b0, lane[15:0]};
            default: ext_rdata = mem_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a handshaked data memory.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | waiting for a request; stall follows i_req_valid
//   ST_REQ     | memory request driven, waiting for i_mem_ready
//   ST_WAIT    | load accepted, waiting for i_mem_valid
//   ST_DONE    | one-cycle completion pulse
//   ST_ERR_MIS | misaligned access trapped, no memory access made
//   ST_ERR_BUS | REQ/WAIT exceeded TIMEOUT_CYC cycles
module dmem_lsu_ctrl
    import dmem_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_wen,
    input  logic [2:0]  i_opsel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_mem_req,
    input  logic        i_mem_ready,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_mask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    // A zero timeout disables the counter; keep it at least one bit wide.
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    lsu_state_t        state;
    logic              wen_q;
    logic [2:0]        opsel_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_expire;

    logic [31:0]       dm_addr;
    logic [3:0]        dm_mask;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    dmem_lsu_ctrl_dmem u_dmem (
        .opsel     (opsel_q),
        .addr      (addr_q),
        .wdata     (wdata_q),
        .mem_rdata (i_mem_rdata),
        .mem_addr  (dm_addr),
        .mem_mask  (dm_mask),
        .mem_wdata (dm_wdata),
        .ext_rdata (dm_rdata)
    );

    // The current REQ/WAIT cycle is the last one allowed
    assign tmo_expire = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    // Pipeline freeze: combinational in IDLE so the request stalls its own cycle
    assign o_stall = ((state == ST_IDLE) && i_req_valid) || (state == ST_REQ) || (state == ST_WAIT);

    // Memory-side fields are held at zero whenever no request is outstanding
    assign o_mem_wen   = o_mem_req & wen_q;
    assign o_mem_addr  = o_mem_req ? dm_addr  : '0;
    assign o_mem_mask  = o_mem_req ? dm_mask  : '0;
    assign o_mem_wdata = o_mem_req ? dm_wdata : '0;

    // Sequencer FSM with registered handshake/completion outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            wen_q      <= 1'b0;
            opsel_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tmo_cnt    <= '0;
            o_done     <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            o_mem_req  <= 1'b0;
            o_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        wen_q   <= i_req_wen;
                        opsel_q <= i_opsel;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        if (is_misaligned(i_opsel[1:0], i_addr[1:0])) begin
                            state      <= ST_ERR_MIS;
                            o_done     <= 1'b1;
                            o_misalign <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            o_mem_req <= 1'b1;
                            tmo_cnt   <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    // Acceptance in the expiry cycle still completes normally
                    if (i_mem_ready) begin
                        o_mem_req <= 1'b0;
                        if (wen_q) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (tmo_expire) begin
                        state     <= ST_ERR_BUS;
                        o_mem_req <= 1'b0;
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (i_mem_valid) begin
                        state   <= ST_DONE;
                        o_done  <= 1'b1;
                        o_rdata <= dm_rdata;
                    end else if (tmo_expire) begin
                        state     <= ST_ERR_BUS;
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    o_done     <= 1'b0;
                    o_misalign <= 1'b0;
                    o_bus_err  <= 1'b0;
                    o_mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule
